// File: rtl/mem_pkg.sv
// Shared types and constants for the word memory and its copy engine.
package mem_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 8;
  localparam int WORD_STEP  = WORD_BYTES;
  localparam int DATA_W     = 8 * WORD_BYTES;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WAIT,
    WRITE,
    DONE
  } state_t;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-copy bus master for the word memory: per word, read src, wait one
// cycle for the read data, then write it to dst.
module mem_copy_engine
  import mem_pkg::*;
#(
  parameter int W      = mem_pkg::WORD_BYTES,
  parameter int Addr_W = mem_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              inp_start,
  input  logic [Addr_W-1:0] inp_src_addr,
  input  logic [Addr_W-1:0] inp_dst_addr,
  input  logic [Addr_W-1:0] inp_word_count,
  input  logic [8*W-1:0]    inp_mem_read_data,
  output logic [Addr_W-1:0] out_mem_address,
  output logic [8*W-1:0]    out_mem_data,
  output logic              out_mem_write_enable,
  output logic              out_busy,
  output logic              out_done,
  output logic [Addr_W-1:0] out_words_copied
);

  localparam logic [Addr_W-1:0] STEP = Addr_W'(W);
  localparam logic [Addr_W-1:0] ONE  = Addr_W'(1);

  state_t            state;
  state_t            state_nxt;
  logic [Addr_W-1:0] src;
  logic [Addr_W-1:0] dst;
  logic [Addr_W-1:0] remaining;
  logic [Addr_W-1:0] words_copied;
  logic [8*W-1:0]    data_latch;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Bus outputs decode from the state register only, so an async reset
  // drops write_enable at once rather than at the next edge.
  always_comb begin
    state_nxt            = state;
    out_mem_address      = '0;
    out_mem_data         = '0;
    out_mem_write_enable = 1'b0;
    out_busy             = 1'b0;
    out_done             = 1'b0;
    case (state)
      IDLE: begin
        if (inp_start) state_nxt = (inp_word_count == '0) ? DONE : READ;
      end
      READ: begin
        out_mem_address = src;
        out_busy        = 1'b1;
        state_nxt       = WAIT;
      end
      WAIT: begin
        out_mem_address = src;
        out_busy        = 1'b1;
        state_nxt       = WRITE;
      end
      WRITE: begin
        out_mem_address      = dst;
        out_mem_data         = data_latch;
        out_mem_write_enable = 1'b1;
        out_busy             = 1'b1;
        state_nxt            = (remaining == ONE) ? DONE : READ;
      end
      DONE: begin
        out_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Address arithmetic wraps modulo 2^Addr_W by design.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      src          <= '0;
      dst          <= '0;
      remaining    <= '0;
      words_copied <= '0;
      data_latch   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (inp_start) begin
            src          <= inp_src_addr;
            dst          <= inp_dst_addr;
            remaining    <= inp_word_count;
            words_copied <= '0;
          end
        end
        WAIT: data_latch <= inp_mem_read_data;
        WRITE: begin
          src          <= src + STEP;
          dst          <= dst + STEP;
          remaining    <= remaining - ONE;
          words_copied <= words_copied + ONE;
        end
        default: ;
      endcase
    end
  end

  assign out_words_copied = words_copied;

endmodule

// File: tb/tb_mem_copy_engine.sv
// Directed bench: word memory model plus copy engine, with a scoreboard of expected writes.
module tb_mem_copy_engine;

  typedef struct packed {
    logic [7:0]  addr;
    logic [31:0] data;
  } wr_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        inp_start = 1'b0;
  logic [7:0]  inp_src_addr = '0;
  logic [7:0]  inp_dst_addr = '0;
  logic [7:0]  inp_word_count = '0;
  logic [31:0] inp_mem_read_data;
  logic [7:0]  out_mem_address;
  logic [31:0] out_mem_data;
  logic        out_mem_write_enable;
  logic        out_busy;
  logic        out_done;
  logic [7:0]  out_words_copied;

  logic        tb_own = 1'b0;
  logic [7:0]  tb_addr = '0;
  logic [31:0] tb_wdata = '0;
  logic        tb_we = 1'b0;
  logic [7:0]  m_addr;
  logic [31:0] m_wdata;
  logic        m_we;

  logic [31:0] mem    [64];
  logic [31:0] shadow [64];
  wr_t         exp_q[$];

  int checks = 0;
  int passes = 0;
  int fails = 0;
  int writes_seen = 0;
  int done_pulses = 0;
  int cyc = 0;
  int accept_cyc = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  mem_copy_engine #(.W(4), .Addr_W(8)) dut (
    .clk                 (clk),
    .reset               (reset),
    .inp_start           (inp_start),
    .inp_src_addr        (inp_src_addr),
    .inp_dst_addr        (inp_dst_addr),
    .inp_word_count      (inp_word_count),
    .inp_mem_read_data   (inp_mem_read_data),
    .out_mem_address     (out_mem_address),
    .out_mem_data        (out_mem_data),
    .out_mem_write_enable(out_mem_write_enable),
    .out_busy            (out_busy),
    .out_done            (out_done),
    .out_words_copied    (out_words_copied)
  );

  assign m_addr  = tb_own ? tb_addr  : out_mem_address;
  assign m_wdata = tb_own ? tb_wdata : out_mem_data;
  assign m_we    = tb_own ? tb_we    : out_mem_write_enable;
  assign inp_mem_read_data = mem[m_addr[7:2]];

  always @(posedge clk) if (m_we) mem[m_addr[7:2]] <= m_wdata;

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else begin
      fails++;
      $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every engine write must match the next queued expectation.
  always @(negedge clk) begin
    if (out_done) done_pulses++;
    if (!tb_own && out_mem_write_enable) begin
      wr_t e;
      writes_seen++;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
      check("engine_write", {out_mem_address, out_mem_data}, e);
    end
  end

  task automatic preload(input logic [7:0] a, input logic [31:0] d);
    @(negedge clk);
    tb_own   = 1'b1;
    tb_addr  = a;
    tb_wdata = d;
    tb_we    = 1'b1;
    shadow[a[7:2]] = d;
    @(negedge clk);
    tb_we  = 1'b0;
    tb_own = 1'b0;
  endtask

  task automatic expect_copy(input logic [7:0] src, input logic [7:0] dst, input int n);
    logic [7:0]  s, d;
    logic [31:0] v;
    for (int i = 0; i < n; i++) begin
      s = src + 8'(4 * i);
      d = dst + 8'(4 * i);
      v = shadow[s[7:2]];
      shadow[d[7:2]] = v;
      exp_q.push_back({d, v});
    end
  endtask

  task automatic start_copy(input logic [7:0] src, input logic [7:0] dst, input logic [7:0] n,
                            input bit push);
    @(negedge clk);
    check("done_low_before_start", 40'(out_done), 40'd0);
    inp_start      = 1'b1;
    inp_src_addr   = src;
    inp_dst_addr   = dst;
    inp_word_count = n;
    if (push) expect_copy(src, dst, int'(n));
    @(posedge clk);
    #1;
    accept_cyc = cyc;
    inp_start  = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int exp_lat, output int busy_seen,
                           output int we_seen);
    int lat;
    lat = 0;
    busy_seen = 0;
    we_seen = 0;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (out_busy) busy_seen++;
      if (out_mem_write_enable) we_seen++;
      if (out_done) begin
        lat = cyc - accept_cyc + 1;
        break;
      end
    end
    check(tag, 40'(lat), 40'(exp_lat));
  endtask

  task automatic check_mem(input string tag, input logic [7:0] a);
    check(tag, 40'(mem[a[7:2]]), 40'(shadow[a[7:2]]));
  endtask

  initial begin
    int b, w, w0, d0;
    for (int i = 0; i < 64; i++) begin
      mem[i]    = '0;
      shadow[i] = '0;
    end

    // Reset state
    @(negedge clk);
    check("reset_addr",  40'(out_mem_address), 40'd0);
    check("reset_data",  40'(out_mem_data), 40'd0);
    check("reset_we",    40'(out_mem_write_enable), 40'd0);
    check("reset_busy",  40'(out_busy), 40'd0);
    check("reset_done",  40'(out_done), 40'd0);
    check("reset_count", 40'(out_words_copied), 40'd0);
    reset = 1'b0;

    // 1 + 3: basic copy with an ignored start mid-copy
    preload(8'h00, 32'h01);
    preload(8'h04, 32'h23);
    preload(8'h08, 32'h45);
    for (int i = 0; i < 5; i++) preload(8'(8'h80 + 4 * i), 32'hC0DE_0000 + 32'(i));
    w0 = writes_seen;
    start_copy(8'h00, 8'h40, 8'd3, 1'b1);
    @(negedge clk);
    check("busy_in_read", 40'(out_busy), 40'd1);
    inp_start      = 1'b1;
    inp_src_addr   = 8'h80;
    inp_dst_addr   = 8'h60;
    inp_word_count = 8'd5;
    @(negedge clk);
    inp_start = 1'b0;
    wait_done("s1_done_latency", 10, b, w);
    check("s1_words_copied", 40'(out_words_copied), 40'd3);
    check("s1_done_busy_low", 40'(out_busy), 40'd0);
    for (int i = 0; i < 3; i++) begin
      check_mem("s1_dst_word", 8'(8'h40 + 4 * i));
      check_mem("s1_src_word", 8'(4 * i));
    end
    for (int i = 0; i < 5; i++) check_mem("s3_region_80", 8'(8'h80 + 4 * i));
    check_mem("s3_region_60", 8'h60);
    @(negedge clk);
    check("s3_write_count", 40'(writes_seen - w0), 40'd3);
    check("s1_count_held_idle", 40'(out_words_copied), 40'd3);
    check("s1_queue_empty", 40'(exp_q.size()), 40'd0);

    // 2: zero-length copy
    w0 = writes_seen;
    start_copy(8'h00, 8'h50, 8'd0, 1'b1);
    wait_done("s2_done_latency", 1, b, w);
    check("s2_busy_never", 40'(b), 40'd0);
    check("s2_we_never", 40'(writes_seen - w0), 40'd0);
    check("s2_words_copied", 40'(out_words_copied), 40'd0);

    // 4: source wraps past the top of the address space
    preload(8'hF8, 32'hAA);
    preload(8'hFC, 32'hBB);
    preload(8'h00, 32'hCC);
    start_copy(8'hF8, 8'h20, 8'd3, 1'b1);
    wait_done("s4_done_latency", 10, b, w);
    check_mem("s4_dst_20", 8'h20);
    check_mem("s4_dst_24", 8'h24);
    check_mem("s4_dst_28", 8'h28);
    check("s4_dst_28_value", 40'(mem[8'h28 >> 2]), 40'hCC);
    check("s4_words_copied", 40'(out_words_copied), 40'd3);

    // 5: async reset during WAIT of the second word
    preload(8'h60, 32'h5A5A5A5A);
    preload(8'h64, 32'h5A5A5A5A);
    preload(8'h68, 32'h5A5A5A5A);
    start_copy(8'h00, 8'h60, 8'd3, 1'b0);
    expect_copy(8'h00, 8'h60, 1);
    for (int i = 0; i < 5; i++) @(negedge clk);
    check("s5_busy_before_reset", 40'(out_busy), 40'd1);
    reset = 1'b1;
    #1;
    check("s5_we_after_reset", 40'(out_mem_write_enable), 40'd0);
    check("s5_busy_after_reset", 40'(out_busy), 40'd0);
    check("s5_addr_after_reset", 40'(out_mem_address), 40'd0);
    check("s5_count_after_reset", 40'(out_words_copied), 40'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("s5_idle_busy", 40'(out_busy), 40'd0);
    check_mem("s5_dst_60", 8'h60);
    check_mem("s5_dst_64", 8'h64);
    check_mem("s5_dst_68", 8'h68);
    check("s5_queue_empty", 40'(exp_q.size()), 40'd0);

    // 5b: async reset inside WRITE kills the pending write before the edge
    preload(8'h70, 32'h77);
    start_copy(8'h04, 8'h70, 8'd1, 1'b0);
    @(posedge clk);
    @(posedge clk);
    #1;
    check("s5b_we_in_write", 40'(out_mem_write_enable), 40'd1);
    reset = 1'b1;
    #1;
    check("s5b_we_dropped", 40'(out_mem_write_enable), 40'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_mem("s5b_dst_70", 8'h70);

    // 6: back-to-back copies, second start in the cycle after done
    d0 = done_pulses;
    start_copy(8'h00, 8'h90, 8'd2, 1'b1);
    wait_done("s6a_done_latency", 7, b, w);
    check("s6a_words_copied", 40'(out_words_copied), 40'd2);
    start_copy(8'h08, 8'hA0, 8'd1, 1'b1);
    wait_done("s6b_done_latency", 4, b, w);
    check("s6b_words_copied", 40'(out_words_copied), 40'd1);
    check_mem("s6_dst_90", 8'h90);
    check_mem("s6_dst_94", 8'h94);
    check_mem("s6_dst_a0", 8'hA0);
    @(negedge clk);
    check("s6_done_pulses", 40'(done_pulses - d0), 40'd2);
    check("s6_queue_empty", 40'(exp_q.size()), 40'd0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not finish within time limit");
    $fatal(1, "timeout");
  end

endmodule
